dcache_refill_ctrl: RTL and testbench
=====================================

// Module: dcache_refill_ctrl
// PURPOSE
// Miss-refill controller directly downstream of the data cache (dataMemory). When a load/store
// hits missFlag, it stalls the CPU, fetches the missing block from the next memory level over a
// valid/ready request + valid response interface, streams the words into the cache fill port,
// then releases the stall so the access replays and hits.
// PARAMETERS
// ADDR_W           32  byte-address width
// DATA_W           32  data word width
// WORDS_PER_BLOCK  2   words per cache block; power of 2, >=2 (2 -> 8-byte block, addr[31:3])
// TIMEOUT_CYCLES   64  max cycles without handshake progress before error; 1..65535
// PORTS
// clk              in   1                clock, all state on rising edge
// reset            in   1                synchronous, active-high
// req_valid        in   1                CPU memory access (load or store) present this cycle
// req_addr         in   ADDR_W           CPU byte address
// miss             in   1                missFlag from data cache for req_addr
// stall            out  1                freeze PC/pipeline; access replays when low
// mem_req_valid    out  1                block read request to next level
// mem_req_ready    in   1                next level accepts request
// mem_req_addr     out  ADDR_W           block-aligned byte address (offset bits zero)
// mem_rsp_valid    in   1                one response word this cycle
// mem_rsp_data     in   DATA_W           response word, beats in ascending word order
// fill_valid       out  1                write fill_data into cache line
// fill_block_addr  out  ADDR_W-OFF_W     block address, OFF_W = $clog2(WORDS_PER_BLOCK*4)
// fill_word_idx    out  $clog2(WPB)      word index within block
// fill_data        out  DATA_W           word to write
// fill_done        out  1                block complete; cache marks line valid
// timeout_err      out  1                sticky refill timeout
// BEHAVIOUR
// - One clock (clk); reset synchronous, active-high. Reset: state IDLE; all outputs 0 (stall,
//   mem_req_valid, fill_valid, fill_done, timeout_err, addr/idx/data regs); counters 0.
// - States: IDLE, REQ, WAIT_RSP, DONE, ERR.
// - IDLE: req_valid&&miss -> capture blk=req_addr[ADDR_W-1:OFF_W], go REQ. stall is
//   combinational: stall = (state!=IDLE) || (req_valid&&miss), so the missing cycle is stalled.
//   miss without req_valid ignored. mem_rsp_valid ignored outside WAIT_RSP.
// - REQ: mem_req_valid=1, mem_req_addr={blk,OFF_W'b0}, held stable until mem_req_ready;
//   handshake -> WAIT_RSP, beat=0. req_addr/miss changes during refill ignored.
// - WAIT_RSP: each mem_rsp_valid registers one fill: next cycle fill_valid=1, fill_word_idx=beat,
//   fill_data=mem_rsp_data, fill_block_addr=blk; beat++. Gaps between beats allowed.
//   Last beat (beat==WPB-1) -> DONE.
// - DONE (one cycle): fill_valid for last word AND fill_done=1; -> IDLE. stall low first IDLE cycle.
// - Min latency (ready and rsp immediate, WPB=2): miss cyc0, REQ cyc1, beats cyc2-3, DONE cyc4,
//   stall low cyc5 -> 5 stall cycles.
// - Timeout: counter clears on entry to REQ and on each handshake (req accept or rsp beat),
//   else increments in REQ/WAIT_RSP; reaching TIMEOUT_CYCLES -> ERR. ERR: timeout_err=1,
//   stall=1, mem_req_valid=0, no fills; only reset exits.
// - Reset mid-refill: IDLE next edge, partial block discarded, fill_done never pulses.
// - A new miss is accepted only in IDLE; back-to-back misses cost full latency each.
// TESTING
// 1 Load miss addr 0x00001028, ready=1, rsp 0x11111111,0x22222222 back-to-back -> mem_req_addr
//   0x00001028, fills idx0/1 with blk 0x205, fill_done with idx1, stall high exactly 5 cycles.
// 2 Ready held low 3 cycles -> mem_req_valid/addr stable all 4 cycles; one request only.
// 3 Rsp beats separated by 2 idle cycles -> fill_valid only after beats, order idx0 then idx1.
// 4 No rsp after acceptance, TIMEOUT_CYCLES=8 -> ERR after 8 idle cycles, timeout_err=1,
//   stall stuck 1; reset -> all outputs 0.
// 5 Reset asserted after first beat -> IDLE next cycle, no fill_done, stall 0 at once.
// 6 miss=1 with req_valid=0 -> no request, stall 0; rsp_valid in IDLE -> no fill_valid.

Source files
------------

// File: rtl/dcache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_refill_ctrl
//
// Purpose:
//   Miss-refill controller that sits directly downstream of the data cache.
//   When a load/store misses, the CPU is stalled. The missing block is then
//   fetched from the next memory level: one valid/ready block request is
//   issued, followed by WORDS_PER_BLOCK response beats. Each beat is
//   registered into the cache fill port. fill_done pulses with the final word
//   and the stall is released, so the access replays and hits.
//   If no handshake progress is made for TIMEOUT_CYCLES cycles, the
//   controller parks in an error state. Only reset leaves that state.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   reset            synchronous, active-high
//   req_valid        CPU memory access present this cycle
//   req_addr         CPU byte address
//   miss             cache miss flag for req_addr
//   stall            freeze PC/pipeline (combinational)
//   mem_req_valid    block read request to next level
//   mem_req_ready    next level accepts the request
//   mem_req_addr     block-aligned byte address of the request
//   mem_rsp_valid    one response word this cycle
//   mem_rsp_data     response word, ascending word order
//   fill_valid       write fill_data into the cache line
//   fill_block_addr  block address being filled
//   fill_word_idx    word index within the block
//   fill_data        word to write
//   fill_done        block complete, cache marks the line valid
//   timeout_err      sticky refill timeout indication
// ---------------------------------------------------------------------------
module dcache_refill_ctrl #(
  parameter  int ADDR_W          = 32,
  parameter  int DATA_W          = 32,
  parameter  int WORDS_PER_BLOCK = 2,
  parameter  int TIMEOUT_CYCLES  = 64,
  localparam int OFF_W           = $clog2(WORDS_PER_BLOCK * 4),
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK),
  localparam int BLK_W           = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              miss,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              fill_valid,
  output logic [BLK_W-1:0]  fill_block_addr,
  output logic [IDX_W-1:0]  fill_word_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_done,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_DONE     = 3'd3,
    S_ERR      = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [16:0]      TMO_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t              r_state;
  state_t              w_state_next;

  logic [BLK_W-1:0]    r_blk;
  logic [IDX_W-1:0]    r_beat;
  logic [15:0]         r_tmo;
  logic                r_fill_valid;
  logic [IDX_W-1:0]    r_fill_idx;
  logic [DATA_W-1:0]   r_fill_data;

  logic                w_capture;
  logic                w_req_hs;
  logic                w_beat;
  logic                w_tmo_expire;

  // Byte-offset bits of the CPU address are irrelevant for a block refill.
  logic                w_unused_offset;
  assign w_unused_offset = &{1'b0, req_addr[OFF_W-1:0]};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_capture     = 1'b0;
    w_req_hs      = 1'b0;
    w_beat        = 1'b0;
    // The count is widened by one bit so that +1 can never wrap at 65535.
    w_tmo_expire  = ({1'b0, r_tmo} + 17'd1) >= TMO_LIMIT;
    mem_req_valid = 1'b0;
    fill_done     = 1'b0;
    timeout_err   = 1'b0;
    // The miss cycle itself must already be stalled, so the IDLE term is
    // taken directly from the inputs rather than from a register.
    stall         = (r_state != S_IDLE) || (req_valid && miss);

    case (r_state)
      S_IDLE: begin
        if (req_valid && miss) begin
          w_capture    = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_req_hs     = 1'b1;
          w_state_next = S_WAIT_RSP;
        end else if (w_tmo_expire) begin
          w_state_next = S_ERR;
        end
      end
      S_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          w_beat = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_state_next = S_DONE;
          end
        end else if (w_tmo_expire) begin
          w_state_next = S_ERR;
        end
      end
      S_DONE: begin
        fill_done    = 1'b1;
        w_state_next = S_IDLE;
      end
      S_ERR: begin
        timeout_err  = 1'b1;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: captured block, beat counter, timeout counter, fill registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blk        <= '0;
      r_beat       <= '0;
      r_tmo        <= '0;
      r_fill_valid <= 1'b0;
      r_fill_idx   <= '0;
      r_fill_data  <= '0;
    end else begin
      if (w_capture) begin
        r_blk <= req_addr[ADDR_W-1:OFF_W];
      end

      if (w_req_hs) begin
        r_beat <= '0;
      end else if (w_beat) begin
        r_beat <= r_beat + 1'b1;
      end

      // Counts cycles without progress; any handshake restarts the window.
      // Outside REQ/WAIT_RSP it is held at zero, which also clears it on
      // entry to REQ.
      if ((r_state == S_REQ) || (r_state == S_WAIT_RSP)) begin
        if (w_req_hs || w_beat) begin
          r_tmo <= '0;
        end else if (!w_tmo_expire) begin
          r_tmo <= r_tmo + 16'd1;
        end
      end else begin
        r_tmo <= '0;
      end

      r_fill_valid <= w_beat;
      if (w_beat) begin
        r_fill_idx  <= r_beat;
        r_fill_data <= mem_rsp_data;
      end
    end
  end

  assign mem_req_addr    = {r_blk, {OFF_W{1'b0}}};
  assign fill_valid      = r_fill_valid;
  assign fill_block_addr = r_blk;
  assign fill_word_idx   = r_fill_idx;
  assign fill_data       = r_fill_data;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_refill_ctrl
//
// Purpose:
//   Self-checking bench for dcache_refill_ctrl (WORDS_PER_BLOCK=2,
//   TIMEOUT_CYCLES=8). Each scenario task drives inputs at posedge+1 and
//   checks outputs on the falling edge. Expected block requests and expected
//   fill words are queued as stimulus is applied. A falling-edge monitor pops
//   them when the DUT produces the matching handshake or fill.
// ---------------------------------------------------------------------------
module tb_dcache_refill_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WPB    = 2;
  localparam int TMO    = 8;
  localparam int OFF_W  = 3;
  localparam int IDX_W  = 1;
  localparam int BLK_W  = ADDR_W - OFF_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              miss;
  logic              stall;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              fill_valid;
  logic [BLK_W-1:0]  fill_block_addr;
  logic [IDX_W-1:0]  fill_word_idx;
  logic [DATA_W-1:0] fill_data;
  logic              fill_done;
  logic              timeout_err;

  always #5 clk = ~clk;

  dcache_refill_ctrl #(
    .ADDR_W          (ADDR_W),
    .DATA_W          (DATA_W),
    .WORDS_PER_BLOCK (WPB),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .miss            (miss),
    .stall           (stall),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .fill_valid      (fill_valid),
    .fill_block_addr (fill_block_addr),
    .fill_word_idx   (fill_word_idx),
    .fill_data       (fill_data),
    .fill_done       (fill_done),
    .timeout_err     (timeout_err)
  );

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [BLK_W-1:0]  blk;
    logic [DATA_W-1:0] data;
    logic              done;
  } fill_t;

  fill_t             exp_fill[$];
  logic [ADDR_W-1:0] exp_req[$];
  int                n_vec = 0;
  int                n_err = 0;

  fill_t             mon_got;
  fill_t             mon_exp;
  logic [ADDR_W-1:0] mon_req_exp;

  // Scoreboard monitor: one line per observed transaction.
  always @(negedge clk) begin
    if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
      $display("req  accepted addr=%h", mem_req_addr);
      n_vec++;
      if (exp_req.size() == 0) begin
        n_err++;
        $display("FAIL req_unexpected: got addr=%h, expected no request", mem_req_addr);
      end else begin
        mon_req_exp = exp_req.pop_front();
        if (mem_req_addr !== mon_req_exp) begin
          n_err++;
          $display("FAIL req_addr: got %h, expected %h", mem_req_addr, mon_req_exp);
        end
      end
    end
    if (fill_valid === 1'b1) begin
      mon_got = {fill_word_idx, fill_block_addr, fill_data, fill_done};
      $display("fill idx=%0d blk=%h data=%h done=%b", fill_word_idx, fill_block_addr, fill_data, fill_done);
      n_vec++;
      if (exp_fill.size() == 0) begin
        n_err++;
        $display("FAIL fill_unexpected: got idx=%0d blk=%h data=%h, expected no fill", fill_word_idx, fill_block_addr, fill_data);
      end else begin
        mon_exp = exp_fill.pop_front();
        if (mon_got !== mon_exp) begin
          n_err++;
          $display("FAIL fill_word: got idx=%0d blk=%h data=%h done=%b, expected idx=%0d blk=%h data=%h done=%b",
                   mon_got.idx, mon_got.blk, mon_got.data, mon_got.done,
                   mon_exp.idx, mon_exp.blk, mon_exp.data, mon_exp.done);
        end
      end
    end
    if (fill_done === 1'b1 && fill_valid !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL done_without_fill: fill_done=1 fill_valid=%b, expected fill_valid=1", fill_valid);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid     = 1'b0;
    miss          = 1'b0;
    req_addr      = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  task automatic push_fill(input logic [IDX_W-1:0] idx, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic done);
    fill_t f;
    f.idx  = idx;
    f.blk  = addr[ADDR_W-1:OFF_W];
    f.data = data;
    f.done = done;
    exp_fill.push_back(f);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    n_vec++;
    if ({stall, mem_req_valid, fill_valid, fill_done, timeout_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got stall/mreq/fill/done/err=%b, expected 00000",
               {stall, mem_req_valid, fill_valid, fill_done, timeout_err});
    end
    n_vec++;
    if ({mem_req_addr, fill_block_addr, fill_word_idx, fill_data} !== '0) begin
      n_err++;
      $display("FAIL reset_regs: got addr=%h blk=%h idx=%0d data=%h, expected all 0",
               mem_req_addr, fill_block_addr, fill_word_idx, fill_data);
    end
    reset = 1'b0;
    cyc();
  endtask

  // Minimum-latency load miss: 5 stall cycles.
  task automatic test_basic();
    int stall_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: begin
          req_valid = 1'b1; miss = 1'b1; req_addr = 32'h0000_1028; mem_req_ready = 1'b1;
          exp_req.push_back(32'h0000_1028);
        end
        1: begin req_valid = 1'b0; miss = 1'b0; req_addr = 32'hDEAD_BEE0; end
        2: begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_1111; push_fill(0, 32'h0000_1028, 32'h1111_1111, 1'b0); end
        3: begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2222_2222; push_fill(1, 32'h0000_1028, 32'h2222_2222, 1'b1); end
        default: mem_rsp_valid = 1'b0;
      endcase
      @(negedge clk);
      if (stall === 1'b1) stall_cnt++;
      if (k == 1) begin
        n_vec++;
        if (mem_req_valid !== 1'b1) begin
          n_err++;
          $display("FAIL t1_req_valid: got %b, expected 1", mem_req_valid);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (fill_done !== 1'b1) begin
          n_err++;
          $display("FAIL t1_fill_done: got %b, expected 1", fill_done);
        end
      end
      cyc();
    end
    idle_inputs();
    n_vec++;
    if (stall_cnt != 5) begin
      n_err++;
      $display("FAIL t1_stall_cycles: got %0d, expected 5", stall_cnt);
    end
  endtask

  // Request held off by ready for 3 cycles; address must not move.
  task automatic test_backpressure();
    for (int k = 0; k < 10; k++) begin
      case (k)
        0: begin
          req_valid = 1'b1; miss = 1'b1; req_addr = 32'h0000_2476; mem_req_ready = 1'b0;
          exp_req.push_back(32'h0000_2470);
        end
        1: begin req_valid = 1'b0; miss = 1'b0; req_addr = 32'h0000_9999; end
        4: mem_req_ready = 1'b1;
        5: begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5_0001; push_fill(0, 32'h0000_2476, 32'hA5A5_0001, 1'b0); end
        6: begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5_0002; push_fill(1, 32'h0000_2476, 32'hA5A5_0002, 1'b1); end
        7: mem_rsp_valid = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_2470) begin
          n_err++;
          $display("FAIL t2_req_hold_k%0d: got valid=%b addr=%h, expected valid=1 addr=00002470",
                   k, mem_req_valid, mem_req_addr);
        end
      end
      if (k >= 5 && k <= 7) begin
        n_vec++;
        if (mem_req_valid !== 1'b0) begin
          n_err++;
          $display("FAIL t2_single_req_k%0d: got mem_req_valid=%b, expected 0", k, mem_req_valid);
        end
      end
      if (k == 8) begin
        n_vec++;
        if (stall !== 1'b0) begin
          n_err++;
          $display("FAIL t2_stall_release: got %b, expected 0", stall);
        end
      end
      cyc();
    end
    idle_inputs();
  endtask

  // Response beats separated by two idle cycles.
  task automatic test_rsp_gaps();
    for (int k = 0; k < 9; k++) begin
      case (k)
        0: begin
          req_valid = 1'b1; miss = 1'b1; req_addr = 32'h0000_8000; mem_req_ready = 1'b1;
          exp_req.push_back(32'h0000_8000);
        end
        1: begin req_valid = 1'b0; miss = 1'b0; end
        2: begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0000; push_fill(0, 32'h0000_8000, 32'hCAFE_0000, 1'b0); end
        5: begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0001; push_fill(1, 32'h0000_8000, 32'hCAFE_0001, 1'b1); end
        default: mem_rsp_valid = 1'b0;
      endcase
      @(negedge clk);
      if (k == 3) begin
        n_vec++;
        if (fill_valid !== 1'b1) begin
          n_err++;
          $display("FAIL t3_fill0: got fill_valid=%b, expected 1", fill_valid);
        end
      end
      if (k == 4 || k == 5) begin
        n_vec++;
        if (fill_valid !== 1'b0) begin
          n_err++;
          $display("FAIL t3_gap_k%0d: got fill_valid=%b, expected 0", k, fill_valid);
        end
      end
      if (k == 6) begin
        n_vec++;
        if (fill_done !== 1'b1) begin
          n_err++;
          $display("FAIL t3_fill_done: got %b, expected 1", fill_done);
        end
      end
      if (k == 7) begin
        n_vec++;
        if (stall !== 1'b0) begin
          n_err++;
          $display("FAIL t3_stall_release: got %b, expected 0", stall);
        end
      end
      cyc();
    end
    idle_inputs();
  endtask

  // No response after acceptance; timeout after 8 idle cycles, then reset.
  task automatic test_timeout();
    for (int k = 0; k < 14; k++) begin
      case (k)
        0: begin
          req_valid = 1'b1; miss = 1'b1; req_addr = 32'h0001_0010; mem_req_ready = 1'b1;
          exp_req.push_back(32'h0001_0010);
        end
        1: begin req_valid = 1'b0; miss = 1'b0; end
        11: begin
          mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_0BAD;
          req_valid = 1'b1; miss = 1'b1; req_addr = 32'h0000_4440;
        end
        12: begin mem_rsp_valid = 1'b0; req_valid = 1'b0; miss = 1'b0; end
        default: ;
      endcase
      @(negedge clk);
      if (k == 9) begin
        n_vec++;
        if (timeout_err !== 1'b0 || stall !== 1'b1) begin
          n_err++;
          $display("FAIL t4_before_timeout: got err=%b stall=%b, expected err=0 stall=1", timeout_err, stall);
        end
      end
      if (k >= 10) begin
        n_vec++;
        if ({timeout_err, stall, mem_req_valid, fill_valid} !== 4'b1100) begin
          n_err++;
          $display("FAIL t4_err_k%0d: got err/stall/mreq/fill=%b, expected 1100",
                   k, {timeout_err, stall, mem_req_valid, fill_valid});
        end
      end
      cyc();
    end
    idle_inputs();
    reset = 1'b1;
    cyc();
    @(negedge clk);
    n_vec++;
    if ({stall, mem_req_valid, fill_valid, fill_done, timeout_err} !== 5'b0 ||
        {mem_req_addr, fill_block_addr, fill_word_idx, fill_data} !== '0) begin
      n_err++;
      $display("FAIL t4_reset_clear: got flags=%b addr=%h blk=%h idx=%0d data=%h, expected all 0",
               {stall, mem_req_valid, fill_valid, fill_done, timeout_err},
               mem_req_addr, fill_block_addr, fill_word_idx, fill_data);
    end
    reset = 1'b0;
    cyc();
  endtask

  // Reset lands right after the first beat: partial block dropped.
  task automatic test_reset_mid();
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: begin
          req_valid = 1'b1; miss = 1'b1; req_addr = 32'h0000_0F08; mem_req_ready = 1'b1;
          exp_req.push_back(32'h0000_0F08);
        end
        1: begin req_valid = 1'b0; miss = 1'b0; end
        2: begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_0000; push_fill(0, 32'h0000_0F08, 32'h5555_0000, 1'b0); end
        3: begin reset = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_0001; end
        4: begin reset = 1'b0; mem_rsp_valid = 1'b0; end
        default: ;
      endcase
      @(negedge clk);
      if (k == 3) begin
        n_vec++;
        if (fill_valid !== 1'b1) begin
          n_err++;
          $display("FAIL t5_first_beat: got fill_valid=%b, expected 1", fill_valid);
        end
      end
      if (k >= 4) begin
        n_vec++;
        if ({stall, fill_valid, fill_done, mem_req_valid} !== 4'b0) begin
          n_err++;
          $display("FAIL t5_after_reset_k%0d: got stall/fill/done/mreq=%b, expected 0000",
                   k, {stall, fill_valid, fill_done, mem_req_valid});
        end
      end
      cyc();
    end
    idle_inputs();
  endtask

  // miss without req_valid and responses in IDLE are both ignored.
  task automatic test_idle_ignore();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0, 1: begin miss = 1'b1; req_valid = 1'b0; req_addr = $urandom; mem_req_ready = 1'b1; end
        2: begin miss = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0BAD; end
        default: mem_rsp_valid = 1'b0;
      endcase
      @(negedge clk);
      n_vec++;
      if ({stall, mem_req_valid, fill_valid} !== 3'b0) begin
        n_err++;
        $display("FAIL t6_idle_k%0d: got stall/mreq/fill=%b, expected 000",
                 k, {stall, mem_req_valid, fill_valid});
      end
      cyc();
    end
    idle_inputs();
  endtask

  // Second miss presented while the first finishes; each pays full latency.
  task automatic test_back_to_back();
    int stall_cnt = 0;
    logic [DATA_W-1:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    for (int k = 0; k < 12; k++) begin
      case (k)
        0: begin
          req_valid = 1'b1; miss = 1'b1; req_addr = 32'h0000_3000; mem_req_ready = 1'b1;
          exp_req.push_back(32'h0000_3000);
        end
        1: begin req_valid = 1'b0; miss = 1'b0; end
        2: begin mem_rsp_valid = 1'b1; mem_rsp_data = d[0]; push_fill(0, 32'h0000_3000, d[0], 1'b0); end
        3: begin mem_rsp_valid = 1'b1; mem_rsp_data = d[1]; push_fill(1, 32'h0000_3000, d[1], 1'b1); end
        4: begin
          mem_rsp_valid = 1'b0;
          req_valid = 1'b1; miss = 1'b1; req_addr = 32'h0000_3008;
          exp_req.push_back(32'h0000_3008);
        end
        6: begin req_valid = 1'b0; miss = 1'b0; end
        7: begin mem_rsp_valid = 1'b1; mem_rsp_data = d[2]; push_fill(0, 32'h0000_3008, d[2], 1'b0); end
        8: begin mem_rsp_valid = 1'b1; mem_rsp_data = d[3]; push_fill(1, 32'h0000_3008, d[3], 1'b1); end
        9: mem_rsp_valid = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (stall === 1'b1) stall_cnt++;
      if (k == 6) begin
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_3008) begin
          n_err++;
          $display("FAIL b2b_second_req: got valid=%b addr=%h, expected valid=1 addr=00003008",
                   mem_req_valid, mem_req_addr);
        end
      end
      if (k == 10) begin
        n_vec++;
        if (stall !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_stall_release: got %b, expected 0", stall);
        end
      end
      cyc();
    end
    idle_inputs();
    n_vec++;
    if (stall_cnt != 10) begin
      n_err++;
      $display("FAIL b2b_stall_cycles: got %0d, expected 10", stall_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_rsp_gaps();
    test_timeout();
    test_reset_mid();
    test_idle_ignore();
    test_back_to_back();
    repeat (2) cyc();
    n_vec++;
    if (exp_req.size() != 0) begin
      n_err++;
      $display("FAIL req_leftover: got %0d pending requests, expected 0", exp_req.size());
    end
    n_vec++;
    if (exp_fill.size() != 0) begin
      n_err++;
      $display("FAIL fill_leftover: got %0d pending fills, expected 0", exp_fill.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
